// File: rtl/battleship_pkg.sv
// -----------------------------------------------------------------------------
// battleship_pkg
//   Shared constants, key codes, FSM state type and key-classification helpers
//   for the keyboard targeting stage and the placement stage.
// -----------------------------------------------------------------------------
package battleship_pkg;

  localparam int GRID_DIM  = 6;
  localparam int NUM_CELLS = GRID_DIM * GRID_DIM;

  localparam logic [7:0] KEY_ENTER       = 8'h0D;
  localparam logic [7:0] KEY_BKSP        = 8'h08;
  localparam logic [7:0] KEY_ROW_BASE_UC = 8'h41;  // 'A'
  localparam logic [7:0] KEY_ROW_BASE_LC = 8'h61;  // 'a'
  localparam logic [7:0] KEY_COL_BASE    = 8'h31;  // '1'

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ROW_SET = 3'd1,
    COL_SET = 3'd2,
    FIRE    = 3'd3,
    WAIT    = 3'd4
  } state_t;

  function automatic logic in_range(input logic [7:0] code, input logic [7:0] base);
    return (code >= base) && (code <= base + 8'(GRID_DIM - 1));
  endfunction

  function automatic logic is_row_key(input logic [7:0] code);
    return in_range(code, KEY_ROW_BASE_UC) || in_range(code, KEY_ROW_BASE_LC);
  endfunction

  function automatic logic is_col_key(input logic [7:0] code);
    return in_range(code, KEY_COL_BASE);
  endfunction

  // Every key base (0x41, 0x61, 0x31) has low bits 3'b001, so for any key that
  // passed a range check the field value is simply the low 3 bits minus one.
  function automatic logic [2:0] key_field(input logic [7:0] code);
    return code[2:0] - 3'd1;
  endfunction

endpackage

// File: rtl/cell_onehot_enc.sv
// -----------------------------------------------------------------------------
// cell_onehot_enc
//   Combinational decoder from a (row, col) grid coordinate to a one-hot cell
//   vector, bit index = row*GRID_DIM + col. Out-of-grid coordinates give 0.
// Ports:
//   row    in  3          row index (A=0)
//   col    in  3          column index ('1'=0)
//   onehot out NUM_CELLS  one-hot selected cell
// -----------------------------------------------------------------------------
module cell_onehot_enc
  import battleship_pkg::*;
(
  input  logic [2:0]           row,
  input  logic [2:0]           col,
  output logic [NUM_CELLS-1:0] onehot
);

  logic [5:0] idx;

  always_comb begin
    idx    = 6'(row) * 6'(GRID_DIM) + 6'(col);
    onehot = '0;
    if ((row < 3'(GRID_DIM)) && (col < 3'(GRID_DIM))) begin
      onehot = NUM_CELLS'(36'd1) << idx;
    end
  end

endmodule

// File: rtl/fire_control.sv
// -----------------------------------------------------------------------------
// fire_control
//   Keyboard-driven targeting stage. Collects a row letter (A-F / a-f) and a
//   column digit (1-6), and on Enter issues a one-cycle fire pulse with a
//   one-hot target held stable until the resolver's result window elapses.
//   Tracks the set of cells fired at and a saturating shot count.
//
//   Build option: define REPEAT_SHOT_BLOCK_EN to reject Enter on a cell that
//   was already fired at (entry_err, stays in COL_SET, no fire).
//
// Ports:
//   clk           in   1   system clock
//   reset         in   1   synchronous, active-low reset
//   turn_en       in   1   this player's turn; key entry ignored when low
//   key_valid     in   1   one-cycle strobe, key_code valid
//   key_code      in   8   ASCII byte from keyboard decoder
//   target        out  36  one-hot selected cell, nonzero from FIRE through WAIT
//   fire          out  1   one-cycle pulse, target valid in same cycle
//   busy          out  1   high in FIRE and WAIT
//   entry_err     out  1   one-cycle pulse the cycle after a rejected key
//   shot_history  out  36  bit set for every cell fired at
//   shots_fired   out  6   number of fires, saturates at 36
//   state         out  3   current FSM state (debug observation)
//
// Key handshake: a key is consumed on the rising edge where key_valid=1 and
// turn_en=1; there is no back-pressure. Keys arriving in FIRE or WAIT are
// dropped silently.
// -----------------------------------------------------------------------------
module fire_control
  import battleship_pkg::*;
#(
  parameter int RESULT_WAIT = 3
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 turn_en,
  input  logic                 key_valid,
  input  logic [7:0]           key_code,
  output logic [NUM_CELLS-1:0] target,
  output logic                 fire,
  output logic                 busy,
  output logic                 entry_err,
  output logic [NUM_CELLS-1:0] shot_history,
  output logic [5:0]           shots_fired,
  output state_t               state
);

  localparam logic [7:0] WAIT_LAST = 8'(RESULT_WAIT - 1);
  localparam logic [5:0] SHOT_MAX  = 6'(NUM_CELLS);

  logic [2:0]           row_q;
  logic [2:0]           col_q;
  logic [7:0]           wait_cnt;
  logic [NUM_CELLS-1:0] sel_onehot;

  logic       key_act;
  logic       k_row;
  logic       k_col;
  logic       k_bksp;
  logic       k_enter;
  logic [2:0] k_val;
  logic       repeat_cell;

  cell_onehot_enc u_enc (
    .row    (row_q),
    .col    (col_q),
    .onehot (sel_onehot)
  );

  always_comb begin
    key_act     = key_valid & turn_en;
    k_row       = is_row_key(key_code);
    k_col       = is_col_key(key_code);
    k_bksp      = (key_code == KEY_BKSP);
    k_enter     = (key_code == KEY_ENTER);
    k_val       = key_field(key_code);
    repeat_cell = |(sel_onehot & shot_history);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      wait_cnt     <= '0;
      target       <= '0;
      fire         <= 1'b0;
      busy         <= 1'b0;
      entry_err    <= 1'b0;
      shot_history <= '0;
      shots_fired  <= '0;
    end else begin
      fire      <= 1'b0;
      entry_err <= 1'b0;
      case (state)
        IDLE: begin
          if (key_act) begin
            if (k_row) begin
              row_q <= k_val;
              state <= ROW_SET;
            end else if (!k_bksp) begin
              // Column before row, Enter with nothing selected, or unknown key.
              entry_err <= 1'b1;
            end
          end
        end

        ROW_SET: begin
          if (key_act) begin
            if (k_row) begin
              row_q <= k_val;
            end else if (k_col) begin
              col_q <= k_val;
              state <= COL_SET;
            end else if (k_bksp) begin
              row_q <= '0;
              state <= IDLE;
            end else begin
              entry_err <= 1'b1;
            end
          end
        end

        COL_SET: begin
          if (key_act) begin
            if (k_row) begin
              row_q <= k_val;
            end else if (k_col) begin
              col_q <= k_val;
            end else if (k_bksp) begin
              col_q <= '0;
              state <= ROW_SET;
            end else if (k_enter) begin
`ifdef REPEAT_SHOT_BLOCK_EN
              if (repeat_cell) begin
                entry_err <= 1'b1;
              end else begin
                state        <= FIRE;
                fire         <= 1'b1;
                busy         <= 1'b1;
                target       <= sel_onehot;
                shot_history <= shot_history | sel_onehot;
                if (shots_fired != SHOT_MAX) shots_fired <= shots_fired + 6'd1;
              end
`else
              // Repeat cells fire normally; history bit is simply re-set.
              state        <= FIRE;
              fire         <= 1'b1;
              busy         <= 1'b1;
              target       <= sel_onehot;
              shot_history <= shot_history | sel_onehot;
              if (shots_fired != SHOT_MAX) shots_fired <= shots_fired + 6'd1;
`endif
            end else begin
              entry_err <= 1'b1;
            end
          end
        end

        FIRE: begin
          // fire/target/history were registered on entry; this is the pulse cycle.
          wait_cnt <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state  <= IDLE;
            busy   <= 1'b0;
            target <= '0;
            row_q  <= '0;
            col_q  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifndef REPEAT_SHOT_BLOCK_EN
  logic unused_repeat;
  assign unused_repeat = repeat_cell;
`endif

endmodule

// File: tb/tb_fire_control.sv
module tb_fire_control;
  import battleship_pkg::*;

  logic        clk;
  logic        reset;
  logic        turn_en;
  logic        key_valid;
  logic [7:0]  key_code;
  logic [35:0] target;
  logic        fire;
  logic        busy;
  logic        entry_err;
  logic [35:0] shot_history;
  logic [5:0]  shots_fired;
  state_t      state;

  int checks   = 0;
  int failures = 0;
  int fire_cnt = 0;
  int err_cnt  = 0;

  fire_control #(.RESULT_WAIT(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .turn_en      (turn_en),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .target       (target),
    .fire         (fire),
    .busy         (busy),
    .entry_err    (entry_err),
    .shot_history (shot_history),
    .shots_fired  (shots_fired),
    .state        (state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters: sample the value held during the cycle ending at this edge.
  always @(posedge clk) begin
    if (fire === 1'b1) fire_cnt++;
    if (entry_err === 1'b1) err_cnt++;
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; key is seen by exactly one rising edge and the
  // task returns at the following falling edge.
  task automatic send_key(input logic [7:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 8'h00;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (target !== 36'h0) begin failures++; $display("FAIL reset_target got=%h exp=0", target); end
    checks++; if (fire !== 1'b0) begin failures++; $display("FAIL reset_fire got=%b exp=0", fire); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (entry_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", entry_err); end
    checks++; if (shot_history !== 36'h0) begin failures++; $display("FAIL reset_hist got=%h exp=0", shot_history); end
    checks++; if (shots_fired !== 6'd0) begin failures++; $display("FAIL reset_shots got=%0d exp=0", shots_fired); end
    checks++; if (state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state, IDLE); end
  endtask

  task automatic test_basic_fire();
    int f0;
    f0 = fire_cnt;
    send_key(8'h42);  // 'B'
    send_key(8'h33);  // '3'
    send_key(KEY_ENTER);
    checks++; if (fire !== 1'b1) begin failures++; $display("FAIL basic_fire got=%b exp=1", fire); end
    checks++; if (target !== 36'h000000100) begin failures++; $display("FAIL basic_target got=%h exp=000000100", target); end
    checks++; if (state !== FIRE) begin failures++; $display("FAIL basic_state got=%0d exp=%0d", state, FIRE); end
    checks++; if (shots_fired !== 6'd1) begin failures++; $display("FAIL basic_shots got=%0d exp=1", shots_fired); end
    checks++; if (shot_history !== 36'h000000100) begin failures++; $display("FAIL basic_hist got=%h exp=000000100", shot_history); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy0 got=%b exp=1", busy); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy%0d got=%b exp=1", i, busy); end
      checks++; if (fire !== 1'b0) begin failures++; $display("FAIL basic_fire_off%0d got=%b exp=0", i, fire); end
      checks++; if (target !== 36'h000000100) begin failures++; $display("FAIL basic_hold%0d got=%h exp=000000100", i, target); end
      checks++; if (state !== WAIT) begin failures++; $display("FAIL basic_wait%0d got=%0d exp=%0d", i, state, WAIT); end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
    checks++; if (target !== 36'h0) begin failures++; $display("FAIL basic_target_end got=%h exp=0", target); end
    checks++; if (state !== IDLE) begin failures++; $display("FAIL basic_state_end got=%0d exp=%0d", state, IDLE); end
    checks++; if (fire_cnt - f0 !== 1) begin failures++; $display("FAIL basic_fire_count got=%0d exp=1", fire_cnt - f0); end
  endtask

  task automatic test_wait_ignore();
    int f0, e0;
    f0 = fire_cnt;
    e0 = err_cnt;
    send_key(8'h66);  // 'f'
    send_key(8'h36);  // '6'
    send_key(KEY_ENTER);
    checks++; if (target !== 36'h800000000) begin failures++; $display("FAIL wait_target got=%h exp=800000000", target); end
    send_key(8'h41);  // 'A' during FIRE
    send_key(8'h31);  // '1' during WAIT
    send_key(KEY_ENTER);
    checks++; if (target !== 36'h800000000) begin failures++; $display("FAIL wait_hold got=%h exp=800000000", target); end
    idle_cycles(2);
    checks++; if (state !== IDLE) begin failures++; $display("FAIL wait_state got=%0d exp=%0d", state, IDLE); end
    checks++; if (target !== 36'h0) begin failures++; $display("FAIL wait_target_end got=%h exp=0", target); end
    checks++; if (fire_cnt - f0 !== 1) begin failures++; $display("FAIL wait_fire_count got=%0d exp=1", fire_cnt - f0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL wait_err_count got=%0d exp=0", err_cnt - e0); end
    checks++; if (shots_fired !== 6'd2) begin failures++; $display("FAIL wait_shots got=%0d exp=2", shots_fired); end
    checks++; if (shot_history !== 36'h800000100) begin failures++; $display("FAIL wait_hist got=%h exp=800000100", shot_history); end
  endtask

  task automatic test_entry_err_bksp();
    send_key(8'h34);  // '4' in IDLE
    checks++; if (entry_err !== 1'b1) begin failures++; $display("FAIL err_col_first got=%b exp=1", entry_err); end
    checks++; if (state !== IDLE) begin failures++; $display("FAIL err_state got=%0d exp=%0d", state, IDLE); end
    send_key(8'h43);  // 'C'
    checks++; if (entry_err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", entry_err); end
    send_key(8'h32);  // '2'
    checks++; if (state !== COL_SET) begin failures++; $display("FAIL bksp_pre got=%0d exp=%0d", state, COL_SET); end
    send_key(KEY_BKSP);
    checks++; if (state !== ROW_SET) begin failures++; $display("FAIL bksp_state got=%0d exp=%0d", state, ROW_SET); end
    send_key(KEY_ENTER);  // Enter with only a row selected
    checks++; if (entry_err !== 1'b1) begin failures++; $display("FAIL err_enter_row got=%b exp=1", entry_err); end
    send_key(8'h7A);      // 'z' unknown
    checks++; if (entry_err !== 1'b1) begin failures++; $display("FAIL err_unknown got=%b exp=1", entry_err); end
    send_key(8'h35);  // '5'
    send_key(KEY_ENTER);
    checks++; if (fire !== 1'b1) begin failures++; $display("FAIL bksp_fire got=%b exp=1", fire); end
    checks++; if (target !== 36'h000010000) begin failures++; $display("FAIL bksp_target got=%h exp=000010000", target); end
    checks++; if (shots_fired !== 6'd3) begin failures++; $display("FAIL bksp_shots got=%0d exp=3", shots_fired); end
    idle_cycles(4);
  endtask

  task automatic test_repeat_shot();
    int f0;
    send_key(8'h41);
    send_key(8'h31);
    send_key(KEY_ENTER);
    checks++; if (target !== 36'h000000001) begin failures++; $display("FAIL rep_first_target got=%h exp=000000001", target); end
    idle_cycles(4);
    f0 = fire_cnt;
    send_key(8'h41);
    send_key(8'h31);
    send_key(KEY_ENTER);
`ifdef REPEAT_SHOT_BLOCK_EN
    checks++; if (entry_err !== 1'b1) begin failures++; $display("FAIL rep_err got=%b exp=1", entry_err); end
    checks++; if (fire !== 1'b0) begin failures++; $display("FAIL rep_nofire got=%b exp=0", fire); end
    checks++; if (state !== COL_SET) begin failures++; $display("FAIL rep_state got=%0d exp=%0d", state, COL_SET); end
    checks++; if (shots_fired !== 6'd4) begin failures++; $display("FAIL rep_shots got=%0d exp=4", shots_fired); end
    send_key(KEY_BKSP);
    send_key(KEY_BKSP);
    idle_cycles(1);
    checks++; if (fire_cnt - f0 !== 0) begin failures++; $display("FAIL rep_fire_count got=%0d exp=0", fire_cnt - f0); end
`else
    checks++; if (fire !== 1'b1) begin failures++; $display("FAIL rep_fire got=%b exp=1", fire); end
    checks++; if (shots_fired !== 6'd5) begin failures++; $display("FAIL rep_shots got=%0d exp=5", shots_fired); end
    checks++; if (shot_history !== 36'h800010101) begin failures++; $display("FAIL rep_hist got=%h exp=800010101", shot_history); end
    idle_cycles(4);
    checks++; if (fire_cnt - f0 !== 1) begin failures++; $display("FAIL rep_fire_count got=%0d exp=1", fire_cnt - f0); end
`endif
    checks++; if (state !== IDLE) begin failures++; $display("FAIL rep_end_state got=%0d exp=%0d", state, IDLE); end
  endtask

  task automatic test_reset_mid();
    int f0;
    send_key(8'h44);  // 'D'
    send_key(8'h34);  // '4'
    pulse_reset();
    checks++; if (state !== IDLE) begin failures++; $display("FAIL rmid_state got=%0d exp=%0d", state, IDLE); end
    checks++; if (shot_history !== 36'h0) begin failures++; $display("FAIL rmid_hist got=%h exp=0", shot_history); end
    checks++; if (shots_fired !== 6'd0) begin failures++; $display("FAIL rmid_shots got=%0d exp=0", shots_fired); end
    checks++; if (target !== 36'h0) begin failures++; $display("FAIL rmid_target got=%h exp=0", target); end
    send_key(KEY_ENTER);
    checks++; if (entry_err !== 1'b1) begin failures++; $display("FAIL rmid_enter_err got=%b exp=1", entry_err); end
    checks++; if (fire !== 1'b0) begin failures++; $display("FAIL rmid_enter_fire got=%b exp=0", fire); end
    // Reset landing in the FIRE cycle: the one pulse already out, nothing after.
    f0 = fire_cnt;
    send_key(8'h41);
    send_key(8'h31);
    send_key(KEY_ENTER);
    pulse_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rfire_busy got=%b exp=0", busy); end
    checks++; if (target !== 36'h0) begin failures++; $display("FAIL rfire_target got=%h exp=0", target); end
    checks++; if (state !== IDLE) begin failures++; $display("FAIL rfire_state got=%0d exp=%0d", state, IDLE); end
    idle_cycles(5);
    checks++; if (fire_cnt - f0 !== 1) begin failures++; $display("FAIL rfire_count got=%0d exp=1", fire_cnt - f0); end
    checks++; if (shots_fired !== 6'd0) begin failures++; $display("FAIL rfire_shots got=%0d exp=0", shots_fired); end
  endtask

  task automatic test_turn_en_low();
    int f0, e0;
    f0 = fire_cnt;
    e0 = err_cnt;
    turn_en = 1'b0;
    send_key(8'h41);
    send_key(8'h31);
    send_key(KEY_ENTER);
    idle_cycles(2);
    checks++; if (fire_cnt - f0 !== 0) begin failures++; $display("FAIL ten_fire got=%0d exp=0", fire_cnt - f0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL ten_err got=%0d exp=0", err_cnt - e0); end
    checks++; if (target !== 36'h0) begin failures++; $display("FAIL ten_target got=%h exp=0", target); end
    checks++; if (state !== IDLE) begin failures++; $display("FAIL ten_state got=%0d exp=%0d", state, IDLE); end
    // Selection survives turn_en dropping mid-entry.
    turn_en = 1'b1;
    send_key(8'h45);  // 'E'
    turn_en = 1'b0;
    send_key(8'h32);  // '2' ignored
    checks++; if (state !== ROW_SET) begin failures++; $display("FAIL ten_keep got=%0d exp=%0d", state, ROW_SET); end
    turn_en = 1'b1;
    send_key(8'h32);
    send_key(KEY_ENTER);
    checks++; if (target !== (36'd1 << 25)) begin failures++; $display("FAIL ten_target_e2 got=%h exp=%h", target, 36'd1 << 25); end
    idle_cycles(4);
  endtask

  task automatic test_saturate();
    logic [35:0] exp_t;
    int idx;
    pulse_reset();
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        idx   = r * 6 + c;
        exp_t = 36'd1 << idx;
        send_key(8'(8'h61 + r));
        send_key(8'(8'h31 + c));
        send_key(KEY_ENTER);
        checks++; if (target !== exp_t) begin failures++; $display("FAIL sat_target%0d got=%h exp=%h", idx, target, exp_t); end
        idle_cycles(4);
      end
    end
    checks++; if (shots_fired !== 6'd36) begin failures++; $display("FAIL sat_shots got=%0d exp=36", shots_fired); end
    checks++; if (shot_history !== 36'hFFFFFFFFF) begin failures++; $display("FAIL sat_hist got=%h exp=FFFFFFFFF", shot_history); end
    send_key(8'h43);
    send_key(8'h33);
    send_key(KEY_ENTER);
`ifdef REPEAT_SHOT_BLOCK_EN
    checks++; if (entry_err !== 1'b1) begin failures++; $display("FAIL sat_rep_err got=%b exp=1", entry_err); end
    send_key(KEY_BKSP);
    send_key(KEY_BKSP);
`else
    checks++; if (fire !== 1'b1) begin failures++; $display("FAIL sat_rep_fire got=%b exp=1", fire); end
    idle_cycles(4);
`endif
    checks++; if (shots_fired !== 6'd36) begin failures++; $display("FAIL sat_hold got=%0d exp=36", shots_fired); end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset     = 1'b0;
    turn_en   = 1'b0;
    key_valid = 1'b0;
    key_code  = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    reset   = 1'b1;
    turn_en = 1'b1;
    @(negedge clk);
    test_basic_fire();
    test_wait_ignore();
    test_entry_err_bksp();
    test_repeat_shot();
    test_reset_mid();
    test_turn_en_low();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a task ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
